// File: rtl/change_dispense_ctrl_if.sv
// Bus between the transaction FSM / dispenser actuator and change_dispense_ctrl.
// slave = controller side, master = FSM/actuator/bench side.
interface change_dispense_ctrl_if;
  localparam int unsigned AMT_W = 8;
  localparam int unsigned DEN_W = 5;

  logic             start;
  logic [AMT_W-1:0] change_amount;
  logic [DEN_W-1:0] stock_ok;
  logic             abort;
  logic             dispense_ack;
  logic             dispense_req;
  logic [DEN_W-1:0] dispense_denom;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] units_out;
  logic             busy;
  logic             done;
  logic             error;

  modport slave (
    input  start, change_amount, stock_ok, abort, dispense_ack,
    output dispense_req, dispense_denom, remaining, units_out, busy, done, error
  );

  modport master (
    output start, change_amount, stock_ok, abort, dispense_ack,
    input  dispense_req, dispense_denom, remaining, units_out, busy, done, error
  );
endinterface

// File: rtl/change_dispense_ctrl.sv
// Greedy change payout (50/20/10/5/1) with a four-phase req/ack handshake to
// the note/coin actuator, one unit at a time; faults on empty stock or ack timeout.
module change_dispense_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 1000,
  parameter int unsigned TO_W        = 10
) (
  input logic                   sys_clk,
  input logic                   sys_rst,
  change_dispense_ctrl_if.slave bus
);
  localparam int unsigned AMT_W = 8;
  localparam int unsigned DEN_W = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_REQ, S_RELEASE, S_DONE, S_FAULT
  } state_t;

  state_t           state_q, state_nxt;
  logic [AMT_W-1:0] rem_q, rem_nxt;
  logic [AMT_W-1:0] units_q, units_nxt;
  logic [DEN_W-1:0] denom_q, denom_nxt;
  logic [TO_W-1:0]  cnt_q, cnt_nxt;
  logic             req_q, busy_q, done_q, error_q;

  // Value of the one-hot denomination currently latched.
  function automatic logic [AMT_W-1:0] denom_value(input logic [DEN_W-1:0] d);
    case (d)
      5'b10000: denom_value = AMT_W'(50);
      5'b01000: denom_value = AMT_W'(20);
      5'b00100: denom_value = AMT_W'(10);
      5'b00010: denom_value = AMT_W'(5);
      5'b00001: denom_value = AMT_W'(1);
      default:  denom_value = '0;
    endcase
  endfunction

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      units_q <= '0;
      denom_q <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      rem_q   <= rem_nxt;
      units_q <= units_nxt;
      denom_q <= denom_nxt;
      cnt_q   <= cnt_nxt;
      req_q   <= (state_nxt == S_REQ);
      busy_q  <= (state_nxt != S_IDLE);
      done_q  <= (state_nxt == S_DONE);
      error_q <= (state_nxt == S_FAULT);
    end
  end

  // Next state and datapath; abort preempts everything outside IDLE.
  always_comb begin
    state_nxt = state_q;
    rem_nxt   = rem_q;
    units_nxt = units_q;
    denom_nxt = denom_q;
    cnt_nxt   = cnt_q;

    if (state_q != S_IDLE && bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            rem_nxt   = bus.change_amount;
            units_nxt = '0;
            state_nxt = (bus.change_amount == '0) ? S_DONE : S_SELECT;
          end
        end
        S_SELECT: begin
          cnt_nxt   = '0;
          state_nxt = S_REQ;
          if      (bus.stock_ok[4] && rem_q >= AMT_W'(50)) denom_nxt = 5'b10000;
          else if (bus.stock_ok[3] && rem_q >= AMT_W'(20)) denom_nxt = 5'b01000;
          else if (bus.stock_ok[2] && rem_q >= AMT_W'(10)) denom_nxt = 5'b00100;
          else if (bus.stock_ok[1] && rem_q >= AMT_W'(5))  denom_nxt = 5'b00010;
          else if (bus.stock_ok[0] && rem_q >= AMT_W'(1))  denom_nxt = 5'b00001;
          else begin
            cnt_nxt   = cnt_q;
            state_nxt = S_FAULT;
          end
        end
        S_REQ: begin
          if (bus.dispense_ack) begin
            rem_nxt   = rem_q - denom_value(denom_q);
            units_nxt = (units_q == '1) ? units_q : units_q + AMT_W'(1);
            state_nxt = S_RELEASE;
          end else if (cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
            state_nxt = S_FAULT;
          end else begin
            cnt_nxt = cnt_q + TO_W'(1);
          end
        end
        S_RELEASE: begin
          if (!bus.dispense_ack) state_nxt = (rem_q == '0) ? S_DONE : S_SELECT;
        end
        S_DONE:  state_nxt = S_IDLE;
        S_FAULT: state_nxt = S_FAULT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.dispense_req   = req_q;
  assign bus.dispense_denom = denom_q;
  assign bus.remaining      = rem_q;
  assign bus.units_out      = units_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.error          = error_q;
endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Scoreboard bench for change_dispense_ctrl: directed payouts push expected
// unit/done/fault events; a negedge monitor pops and compares them.
module tb_change_dispense_ctrl;
  logic clk;
  logic rst;
  change_dispense_ctrl_if ifc ();

  change_dispense_ctrl #(.ACK_TIMEOUT(8), .TO_W(4)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {EV_UNIT, EV_DONE, EV_FAULT} ev_t;
  typedef struct {
    ev_t        kind;
    logic [4:0] denom;
    logic [7:0] rem;
    logic [7:0] units;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic auto_ack  = 1'b0;
  logic ack_auto  = 1'b0;
  logic force_ack = 1'b0;
  logic req_prev  = 1'b0;
  logic err_prev  = 1'b0;

  assign ifc.dispense_ack = auto_ack ? ack_auto : force_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_t k, input logic [4:0] d, input logic [7:0] r, input logic [7:0] u);
    exp_t e;
    e.kind = k; e.denom = d; e.rem = r; e.units = u;
    sb.push_back(e);
  endtask

  task automatic sb_event(input ev_t k);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_unexpected: got event %0d expected none (t=%0t)", int'(k), $time);
    end else begin
      e = sb.pop_front();
      chk("sb_kind", 32'(int'(k)), 32'(int'(e.kind)));
      if (k == EV_UNIT) chk("sb_denom", 32'(ifc.dispense_denom), 32'(e.denom));
      else begin
        chk("sb_remaining", 32'(ifc.remaining), 32'(e.rem));
        chk("sb_units_out", 32'(ifc.units_out), 32'(e.units));
      end
    end
  endtask

  // Actuator model: one-cycle ack pulse in response to each request.
  always @(negedge clk) ack_auto = ifc.dispense_req && !ack_auto;

  // Monitor: new request, done pulse, fault entry.
  always @(negedge clk) begin
    if (ifc.dispense_req && !req_prev) sb_event(EV_UNIT);
    if (ifc.done) sb_event(EV_DONE);
    if (ifc.error && !err_prev) sb_event(EV_FAULT);
    req_prev = ifc.dispense_req;
    err_prev = ifc.error;
  end

  task automatic pulse_start(input logic [7:0] amt);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.change_amount = amt;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!ifc.busy) break;
    end
    if (i == bound) chk("wait_idle_timeout", 32'(1), 32'(0));
  endtask

  initial begin
    int req_cycles;
    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.change_amount = '0;
    ifc.stock_ok = 5'b11111;
    ifc.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(ifc.dispense_req), 0);
    chk("rst_denom", 32'(ifc.dispense_denom), 0);
    chk("rst_remaining", 32'(ifc.remaining), 0);
    chk("rst_units", 32'(ifc.units_out), 0);
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_done", 32'(ifc.done), 0);
    chk("rst_error", 32'(ifc.error), 0);
    rst = 1'b0;

    // 37 with full stock: 20,10,5,1,1
    auto_ack = 1'b1;
    push(EV_UNIT, 5'b01000, 0, 0);
    push(EV_UNIT, 5'b00100, 0, 0);
    push(EV_UNIT, 5'b00010, 0, 0);
    push(EV_UNIT, 5'b00001, 0, 0);
    push(EV_UNIT, 5'b00001, 0, 0);
    push(EV_DONE, 5'b0, 8'd0, 8'd5);
    pulse_start(8'd37);
    chk("t37_busy_select", 32'(ifc.busy), 1);
    chk("t37_req_select", 32'(ifc.dispense_req), 0);
    @(negedge clk);
    chk("t37_req_first", 32'(ifc.dispense_req), 1);
    wait_idle(100);
    chk("t37_units_final", 32'(ifc.units_out), 5);

    // zero amount: done one cycle after start, busy for one cycle
    push(EV_DONE, 5'b0, 8'd0, 8'd0);
    pulse_start(8'd0);
    chk("t0_done", 32'(ifc.done), 1);
    chk("t0_busy", 32'(ifc.busy), 1);
    @(negedge clk);
    chk("t0_busy_after", 32'(ifc.busy), 0);
    chk("t0_done_after", 32'(ifc.done), 0);

    // 30 without 20s: 10,10,10
    ifc.stock_ok = 5'b10111;
    push(EV_UNIT, 5'b00100, 0, 0);
    push(EV_UNIT, 5'b00100, 0, 0);
    push(EV_UNIT, 5'b00100, 0, 0);
    push(EV_DONE, 5'b0, 8'd0, 8'd3);
    pulse_start(8'd30);
    wait_idle(100);

    // 3 without 1s: immediate fault, abort clears
    ifc.stock_ok = 5'b11110;
    push(EV_FAULT, 5'b0, 8'd3, 8'd0);
    pulse_start(8'd3);
    @(negedge clk);
    chk("t3_error", 32'(ifc.error), 1);
    chk("t3_req", 32'(ifc.dispense_req), 0);
    ifc.abort = 1'b1;
    @(negedge clk);
    ifc.abort = 1'b0;
    chk("t3_error_after_abort", 32'(ifc.error), 0);
    chk("t3_busy_after_abort", 32'(ifc.busy), 0);
    chk("t3_remaining_kept", 32'(ifc.remaining), 3);

    // 5 with ack held low: 8 request cycles then fault; late ack ignored
    ifc.stock_ok = 5'b11111;
    auto_ack = 1'b0;
    force_ack = 1'b0;
    push(EV_UNIT, 5'b00010, 0, 0);
    push(EV_FAULT, 5'b0, 8'd5, 8'd0);
    pulse_start(8'd5);
    req_cycles = 0;
    repeat (12) begin
      @(negedge clk);
      if (ifc.dispense_req) req_cycles++;
    end
    chk("t5_req_cycles", 32'(req_cycles), 8);
    chk("t5_error", 32'(ifc.error), 1);
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_late_ack_rem", 32'(ifc.remaining), 5);
    chk("t5_late_ack_units", 32'(ifc.units_out), 0);
    chk("t5_late_ack_error", 32'(ifc.error), 1);
    force_ack = 1'b0;
    ifc.abort = 1'b1;
    @(negedge clk);
    ifc.abort = 1'b0;
    chk("t5_busy_after_abort", 32'(ifc.busy), 0);

    // 50: stray start ignored, abort with coincident ack discards the ack
    push(EV_UNIT, 5'b10000, 0, 0);
    pulse_start(8'd50);
    ifc.start = 1'b1;
    ifc.change_amount = 8'd7;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("t50_req", 32'(ifc.dispense_req), 1);
    ifc.abort = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    ifc.abort = 1'b0;
    force_ack = 1'b0;
    chk("t50_busy", 32'(ifc.busy), 0);
    chk("t50_req_after", 32'(ifc.dispense_req), 0);
    chk("t50_remaining", 32'(ifc.remaining), 50);
    chk("t50_units", 32'(ifc.units_out), 0);

    // reset mid-payout
    auto_ack = 1'b1;
    push(EV_UNIT, 5'b01000, 0, 0);
    pulse_start(8'd37);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_req", 32'(ifc.dispense_req), 0);
    chk("rst_mid_remaining", 32'(ifc.remaining), 0);
    chk("rst_mid_denom", 32'(ifc.dispense_denom), 0);
    chk("rst_mid_busy", 32'(ifc.busy), 0);
    repeat (4) @(negedge clk);

    chk("sb_leftover", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
